uart_transmitter: RTL

Serial UART transmitter; the send side of the board's host link, paired with the existing byte receiver on the same line format. Accepts bytes through a valid/ready handshake into a small internal FIFO. Serializes each byte as a standard 8N1 frame: start bit, 8 data bits LSB first, stop bit. Frames go out back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_transmitter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO and valid/ready input handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       out,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] FULL     = NW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic          r_out;
  logic          r_busy;
  logic [7:0]    r_shift;
`ifdef UART_TX_PARITY_EN
  logic          r_parity;
`endif
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [NW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic          w_frame_end;
  logic          w_idle_next;
  logic [NW-1:0] w_count_next;

  assign ready       = (r_count != FULL);
  assign out         = r_out;
  assign busy        = r_busy;
  assign w_push      = valid && ready;
  assign w_bit_end   = (r_clk_cnt == LAST_CLK);
  assign w_frame_end = (r_state == STOP) && w_bit_end;
  // Pop from IDLE, or straight out of a finished stop bit for gapless frames.
  assign w_pop       = (r_count != '0) && ((r_state == IDLE) || w_frame_end);
  assign w_idle_next = (r_count == '0) && ((r_state == IDLE) || w_frame_end);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
      r_parity <= ^r_mem[r_rd_ptr];
`endif
    end else if ((r_state == DATA) && w_bit_end) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_out     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= !w_idle_next || (w_count_next != '0);
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_out     <= 1'b0;
            r_clk_cnt <= '0;
            r_state   <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_out     <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_out   <= r_parity;
              r_state <= PARITY;
`else
              r_out   <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              // The shift register moves on this same edge, so bit [1] is next.
              r_out     <= r_shift[1];
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_out     <= 1'b1;
            r_state   <= STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (w_pop) begin
              r_out   <= 1'b0;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
